// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the bus-mapped seven-segment display controller:
//   register field positions, reset values, read masks and the hex font.
//
//   Contents:
//     digit_t        - packed view of one DIGIT register
//     CTRL_*         - CTRL register bit positions, mask and reset value
//     DIGIT_MASK     - bits of a DIGIT register that are actually stored
//     SEG_0..SEG_F   - active-high segment patterns, bit order {g,f,e,d,c,b,a}
//     seg7_encode()  - 4-bit hex value to active-high segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

    // One DIGIT register. The reserved field is always stored as zero so a
    // read-back needs no extra masking.
    typedef struct packed {
        logic       blank;
        logic [1:0] rsvd;
        logic       dp;
        logic [3:0] value;
    } digit_t;

    localparam int         DIGIT_DP_BIT    = 4;
    localparam int         DIGIT_BLANK_BIT = 7;
    localparam logic [7:0] DIGIT_MASK      = 8'h9F;

    localparam int         CTRL_EN_BIT = 0;
    localparam int         CTRL_LZ_BIT = 1;
    localparam logic [7:0] CTRL_MASK   = 8'h03;
    localparam logic [7:0] CTRL_RESET  = 8'h01;

    // Active-high segment patterns, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] seg7_encode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
//   Combinational hex-to-seven-segment decoder, active-high outputs.
//
//   Ports:
//     value  in  4  hex digit 0..F
//     seg    out 7  segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_encode(value);
    end

endmodule

// File: rtl/seg7_bus_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_bus_ctrl
//   Bus-mapped, multiplexed seven-segment display controller.
//
//   Register window at BASE_ADDR:
//     offset 0..NUM_DIGITS-1 : DIGIT[k]  [3:0] value, [4] dp, [7] blank
//     offset NUM_DIGITS      : CTRL      [0] enable, [1] leading-zero suppress
//   Reserved bits are stored as zero and therefore read back as zero.
//
//   Bus handshake: a write is taken on any clk_sys rising edge where BUS_WE=1
//   and BUS_ADDR falls in the window. A read is taken on an edge where
//   BUS_WE=0 and the address is in the window; the data is driven onto
//   BUS_DATA for exactly the following cycle and the bus is high-Z otherwise.
//
//   Ports:
//     clk_sys         in    1           system clock
//     rst_n           in    1           asynchronous active-low reset
//     BUS_DATA        inout 8           shared data bus
//     BUS_ADDR        in    8           bus address
//     BUS_WE          in    1           1 = write, 0 = read
//     SEG_SELECT_OUT  out   NUM_DIGITS  digit anodes, active-low
//     HEX_OUT         out   8           {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_bus_ctrl
    import seg7_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hD0,
    parameter int         NUM_DIGITS   = 4,
    parameter int         REFRESH_DIV  = 50000,
    parameter int         GUARD_CYCLES = 4
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [7:0]       CTRL_OFFSET = 8'(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD   = PRE_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    digit_t     digit_q [NUM_DIGITS];
    logic [7:0] ctrl_q;

    logic [7:0] offset;
    logic       in_window;
    logic       wr_hit;
    logic       rd_hit;

    // The subtraction wraps, so addresses below BASE_ADDR land on large
    // offsets and fall outside the window naturally.
    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_window = (offset <= CTRL_OFFSET);
    assign wr_hit    = BUS_WE && in_window;
    assign rd_hit    = !BUS_WE && in_window;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_q[k] <= '0;
            end
            ctrl_q <= CTRL_RESET;
        end else if (wr_hit) begin
            if (offset == CTRL_OFFSET) begin
                ctrl_q <= BUS_DATA & CTRL_MASK;
            end
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (offset == 8'(k)) begin
                    digit_q[k] <= digit_t'(BUS_DATA & DIGIT_MASK);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: one cycle of latency, bus released whenever no read was
    // accepted on the previous edge.
    // ------------------------------------------------------------------
    logic [7:0] rd_value;
    logic [7:0] rd_data_q;
    logic       rd_en_q;

    always_comb begin
        rd_value = '0;
        if (offset == CTRL_OFFSET) begin
            rd_value = ctrl_q;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (offset == 8'(k)) begin
                rd_value = digit_q[k];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_en_q <= rd_hit;
            if (rd_hit) begin
                rd_data_q <= rd_value;
            end
        end
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

    // ------------------------------------------------------------------
    // Scan counters: prescaler sets the slot length, index picks the digit.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection. zero_run[k] is set when every digit from the
    // most significant one down to k holds value 0 with its dp clear.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] zero_run;

    always_comb begin
        logic run;
        zero_run = '0;
        run      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run         = run && (digit_q[k].value == 4'h0) && !digit_q[k].dp;
            zero_run[k] = run;
        end
    end

    // ------------------------------------------------------------------
    // Current slot: pick the scanned digit's fields. Register values are
    // the ones before any write landing on this same edge.
    // ------------------------------------------------------------------
    logic [3:0] cur_value;
    logic       cur_dp;
    logic       cur_blank;
    logic       cur_lead_zero;

    always_comb begin
        cur_value     = '0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        cur_lead_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_value     = digit_q[k].value;
                cur_dp        = digit_q[k].dp;
                cur_blank     = digit_q[k].blank;
                // The rightmost digit always shows, so a lone zero stays visible.
                cur_lead_zero = (k != 0) && zero_run[k];
            end
        end
    end

    logic [6:0] seg;

    seg7_decoder u_decoder (
        .value (cur_value),
        .seg   (seg)
    );

    // ------------------------------------------------------------------
    // Blanking and registered outputs. The guard window at the start of each
    // slot keeps all anodes off while the segment lines change, which stops
    // the previous digit ghosting into the next one.
    // ------------------------------------------------------------------
    logic                  guard;
    logic                  dark;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [7:0]            hex_next;

    assign guard = (pre_q < PRE_GUARD);
    assign dark  = guard
                || !ctrl_q[CTRL_EN_BIT]
                || cur_blank
                || (ctrl_q[CTRL_LZ_BIT] && cur_lead_zero);

    always_comb begin
        sel_next = '1;
        hex_next = 8'hFF;
        if (!dark) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                sel_next[k] = (idx_q != IDX_W'(k));
            end
            hex_next = ~{cur_dp, seg};
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= 8'hFF;
        end else begin
            SEG_SELECT_OUT <= sel_next;
            HEX_OUT        <= hex_next;
        end
    end

endmodule

// File: tb/tb_seg7_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_bus_ctrl
//   Self-checking bench for seg7_bus_ctrl (4 digits, 8-cycle slots, 2 guard
//   cycles). A reference model derives the expected display from the cycle
//   count since reset and a shadow copy of the registers; a monitor compares
//   it every cycle. Directed tables and sequences cover the bus map, scan
//   timing, suppression, enable/blank and reset behaviour; a random phase
//   follows. BUS_DATA carries pull-ups, so a released bus reads as 8'hFF,
//   a value no register can ever return.
// -----------------------------------------------------------------------------
module tb_seg7_bus_ctrl;

  localparam int         ND    = 4;
  localparam int         DIV   = 8;
  localparam int         GUARD = 2;
  localparam logic [7:0] BASE  = 8'hD0;
  localparam logic [7:0] REL   = 8'hFF;  // released-bus reading

  // Active-high font, {g,f,e,d,c,b,a}.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // ---------------- clock / reset / DUT ----------------
  logic          clk_sys  = 1'b0;
  logic          rst_n    = 1'b0;
  wire  [7:0]    BUS_DATA;
  logic [7:0]    BUS_ADDR = 8'h00;
  logic          BUS_WE   = 1'b0;
  logic [ND-1:0] SEG_SELECT_OUT;
  logic [7:0]    HEX_OUT;
  logic          drv_en   = 1'b0;
  logic [7:0]    drv_data = 8'h00;

  always #5 clk_sys = ~clk_sys;

  assign BUS_DATA = drv_en ? drv_data : 8'hzz;

  for (genvar b = 0; b < 8; b++) begin : g_pull
    pullup (BUS_DATA[b]);
  end

  seg7_bus_ctrl #(
    .BASE_ADDR    (BASE),
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (DIV),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .BUS_DATA       (BUS_DATA),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_WE         (BUS_WE),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_reg [ND+1];
  int          cyc     = 0;      // rising edges since reset release
  logic [3:0]  exp_sel = 4'hF;
  logic [7:0]  exp_hex = 8'hFF;
  logic [7:0]  exp_bus = REL;

  function automatic logic [7:0] read_mask(input int off);
    return (off == ND) ? 8'h03 : 8'h9F;
  endfunction

  // Display for the output produced on the edge numbered cyc+1.
  function automatic void model_display(output logic [3:0] s, output logic [7:0] h);
    int  pos;
    int  d;
    bit  lead_zero;
    bit  dark;
    pos       = cyc % DIV;
    d         = (cyc / DIV) % ND;
    lead_zero = (d > 0);
    for (int j = ND - 1; j >= d; j--) begin
      if (m_reg[j][3:0] != 4'h0 || m_reg[j][4]) lead_zero = 1'b0;
    end
    dark = (pos < GUARD) || !m_reg[ND][0] || m_reg[d][7] || (m_reg[ND][1] && lead_zero);
    s = dark ? 4'hF : 4'(~(4'b0001 << d));
    h = dark ? 8'hFF : ~{m_reg[d][4], FONT[m_reg[d][3:0]]};
  endfunction

  initial begin
    for (int j = 0; j < ND; j++) m_reg[j] = 8'h00;
    m_reg[ND] = 8'h01;
    forever begin
      @(posedge clk_sys or negedge rst_n);
      if (!rst_n) begin
        for (int j = 0; j < ND; j++) m_reg[j] = 8'h00;
        m_reg[ND] = 8'h01;
        cyc     = 0;
        exp_sel = 4'hF;
        exp_hex = 8'hFF;
        exp_bus = REL;
      end else begin
        logic [7:0] off;
        model_display(exp_sel, exp_hex);
        off     = BUS_ADDR - BASE;
        exp_bus = REL;
        if (off <= 8'(ND)) begin
          if (BUS_WE) m_reg[off] = BUS_DATA;
          else        exp_bus = m_reg[off] & read_mask(int'(off));
        end
        cyc++;
      end
    end
  end

  // Monitor: compares every cycle on the falling edge. Bus is only checked
  // while the bench itself is not driving it.
  initial begin
    forever begin
      @(negedge clk_sys);
      check("sel", {4'h0, SEG_SELECT_OUT}, {4'h0, exp_sel});
      check("hex", HEX_OUT, exp_hex);
      if (!drv_en) check("bus", BUS_DATA, exp_bus);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge, after the monitor.
  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b1; drv_data = d; drv_en = 1'b1;
    step();
    BUS_WE = 1'b0; drv_en = 1'b0; BUS_ADDR = 8'h00;
  endtask

  // Returns the bus one cycle after the address; then one idle cycle so the
  // DUT has released the bus before the bench drives it again.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b0;
    step();
    d = BUS_DATA;
    BUS_ADDR = 8'h00;
    step();
  endtask

  // Advance until the output shows slot position pos of digit d.
  task automatic wait_out(input int d, input int pos);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(cyc > 0 && (cyc - 1) % DIV == pos && ((cyc - 1) / DIV) % ND == d) && n < 100);
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_out digit=%0d pos=%0d not reached in 100 cycles", d, pos);
    end
  endtask

  task automatic expect_slot(input string name, input int d, input logic [3:0] s, input logic [7:0] h);
    wait_out(d, 4);
    check({name, "_sel"}, {4'h0, SEG_SELECT_OUT}, {4'h0, s});
    check({name, "_hex"}, HEX_OUT, h);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [19];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] rd;
    int         lit [ND];

    // Reset state
    repeat (3) step();
    check("rst_sel", {4'h0, SEG_SELECT_OUT}, 8'h0F);
    check("rst_hex", HEX_OUT, 8'hFF);
    check("rst_bus", BUS_DATA, REL);
    rst_n = 1'b1;

    // Digit 0 shows "0" after the guard cycles
    wait_out(0, 1);
    check("g1_sel", {4'h0, SEG_SELECT_OUT}, 8'h0F);
    check("g1_hex", HEX_OUT, 8'hFF);
    wait_out(0, 2);
    check("d0_first_sel", {4'h0, SEG_SELECT_OUT}, 8'h0E);
    check("d0_first_hex", HEX_OUT, 8'hC0);
    wait_out(0, 7);
    check("d0_last_sel", {4'h0, SEG_SELECT_OUT}, 8'h0E);
    check("d0_last_hex", HEX_OUT, 8'hC0);

    // Scan walk over one full frame
    for (int k = 0; k < ND; k++) lit[k] = 0;
    wait_out(0, 0);
    for (int i = 0; i < 32; i++) begin
      logic [3:0] s;
      s = (i % DIV < GUARD) ? 4'hF : 4'(~(4'b0001 << (i / DIV)));
      check("walk_sel", {4'h0, SEG_SELECT_OUT}, {4'h0, s});
      for (int k = 0; k < ND; k++) if (!SEG_SELECT_OUT[k]) lit[k]++;
      step();
    end
    for (int k = 0; k < ND; k++) check("lit_len", 8'(lit[k]), 8'd6);
    check("walk_wrap_sel", {4'h0, SEG_SELECT_OUT}, 8'h0F);

    // Register map: writes, reads, masking and out-of-window accesses
    vecs = '{
      '{1'b1, 8'hD0, 8'h15, 8'h00}, '{1'b1, 8'hD3, 8'h0A, 8'h00},
      '{1'b0, 8'hD0, 8'h00, 8'h15}, '{1'b0, 8'hD3, 8'h00, 8'h0A},
      '{1'b1, 8'hD1, 8'hFF, 8'h00}, '{1'b0, 8'hD1, 8'h00, 8'h9F},
      '{1'b1, 8'hD4, 8'hFF, 8'h00}, '{1'b0, 8'hD4, 8'h00, 8'h03},
      '{1'b1, 8'hD4, 8'h01, 8'h00}, '{1'b1, 8'hD1, 8'h00, 8'h00},
      '{1'b0, 8'hD5, 8'h00, REL},   '{1'b0, 8'hCF, 8'h00, REL},
      '{1'b1, 8'hD5, 8'h55, 8'h00}, '{1'b1, 8'hCF, 8'h77, 8'h00},
      '{1'b0, 8'hD0, 8'h00, 8'h15}, '{1'b0, 8'hD1, 8'h00, 8'h00},
      '{1'b0, 8'hD2, 8'h00, 8'h00}, '{1'b0, 8'hD3, 8'h00, 8'h0A},
      '{1'b0, 8'hD4, 8'h00, 8'h01}
    };
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), rd, vecs[i].exp);
        check($sformatf("vec%0d_release", i), BUS_DATA, REL);
      end
    end
    expect_slot("d0_5dp", 0, 4'hE, 8'h12);
    expect_slot("d3_A", 3, 4'h7, 8'h88);

    // Leading-zero suppression
    bus_write(8'hD0, 8'h07);
    bus_write(8'hD1, 8'h03);
    bus_write(8'hD2, 8'h00);
    bus_write(8'hD3, 8'h00);
    bus_write(8'hD4, 8'h03);
    expect_slot("lz_d3", 3, 4'hF, 8'hFF);
    expect_slot("lz_d2", 2, 4'hF, 8'hFF);
    expect_slot("lz_d1", 1, 4'hD, 8'hB0);
    expect_slot("lz_d0", 0, 4'hE, 8'hF8);
    bus_write(8'hD3, 8'h10);
    expect_slot("lz_d3dp", 3, 4'h7, 8'h40);
    expect_slot("lz_d2z", 2, 4'hB, 8'hC0);

    // Global disable for a full frame, then per-digit blank
    bus_write(8'hD4, 8'h00);
    for (int i = 0; i < 32; i++) begin
      step();
      check("off_sel", {4'h0, SEG_SELECT_OUT}, 8'h0F);
      check("off_hex", HEX_OUT, 8'hFF);
    end
    bus_write(8'hD1, 8'h80);
    bus_write(8'hD4, 8'h01);
    expect_slot("bl_d1", 1, 4'hF, 8'hFF);
    expect_slot("bl_d2", 2, 4'hB, 8'hC0);
    expect_slot("bl_d3", 3, 4'h7, 8'h40);
    expect_slot("bl_d0", 0, 4'hE, 8'hF8);

    // Asynchronous reset in the middle of slot 2
    expect_slot("pre_rst_d2", 2, 4'hB, 8'hC0);
    rst_n = 1'b0;
    #1;
    check("async_sel", {4'h0, SEG_SELECT_OUT}, 8'h0F);
    check("async_hex", HEX_OUT, 8'hFF);
    step();
    step();
    rst_n = 1'b1;
    expect_slot("post_rst_d0", 0, 4'hE, 8'hC0);
    expect_slot("post_rst_d1", 1, 4'hD, 8'hC0);

    // Random traffic, checked every cycle by the monitor
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      a = BASE - 8'd2 + 8'($urandom_range(0, ND + 3));
      if (a == BASE + 8'(ND)) begin
        case ($urandom_range(0, 3))
          0:       d = 8'h00;
          1:       d = 8'h01;
          default: d = 8'h03;
        endcase
        d = d | (8'($urandom_range(0, 255)) & 8'hFC);
      end else begin
        case ($urandom_range(0, 3))
          0:       d = 8'h00;
          1:       d = 8'h10;
          2:       d = 8'($urandom_range(0, 15));
          default: d = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 9) < 6) bus_write(a, d);
      else                          bus_read(a, rd);
      repeat ($urandom_range(0, 10)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
